// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants for the branch resolution controller: the B-type opcode and recovery FSM states.
package branch_resolve_ctrl_pkg;

`ifndef Btype
`define Btype 7'b1100011
`endif

    localparam logic [6:0] BTYPE_OP = `Btype;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

endpackage

// File: rtl/branch_resolve_ctrl_pipe.sv
// br_pred_pipe: carries {valid, predicted-taken} for each fetched instruction from IF through ID to EXE.
// The pipe holds while stalled. A flush clears both valid bits.
module br_pred_pipe (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic flush,
    input  logic valid_IF,
    input  logic pred_taken_IF,
    output logic v_exe,
    output logic p_exe
);
    logic v_id_reg;
    logic p_id_reg;
    logic v_exe_reg;
    logic p_exe_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_id_reg  <= 1'b0;
            p_id_reg  <= 1'b0;
            v_exe_reg <= 1'b0;
            p_exe_reg <= 1'b0;
        end else if (!stall) begin
            // Flush wins over the normal shift: both slots become bubbles.
            v_id_reg  <= flush ? 1'b0 : valid_IF;
            p_id_reg  <= pred_taken_IF;
            v_exe_reg <= flush ? 1'b0 : v_id_reg;
            p_exe_reg <= p_id_reg;
        end
    end

    assign v_exe = v_exe_reg;
    assign p_exe = p_exe_reg;
endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution and recovery: compares the carried prediction with the EXE outcome, then flushes, redirects and trains the predictor.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Istall,
    input  logic             Dstall,
    input  logic             valid_IF,
    input  logic             pred_taken_IF,
    input  logic [6:0]       opcode_EXE,
    input  logic             jump_sel,
    input  logic [PC_W-1:0]  pc_EXE,
    input  logic [PC_W-1:0]  target_EXE,
    output logic             flush_IF,
    output logic             flush_ID,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             upd_en,
    output logic             upd_taken,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);
    state_t state_reg;
    logic   stall;
    logic   v_exe;
    logic   p_exe;
    logic   is_br;
    logic   mis;
    logic   flush_now;
    logic   upd_fire;
    logic   upd_en_reg;
    logic   upd_taken_reg;

    assign stall = Istall | Dstall;

    br_pred_pipe u_pipe (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush_now),
        .valid_IF      (valid_IF),
        .pred_taken_IF (pred_taken_IF),
        .v_exe         (v_exe),
        .p_exe         (p_exe)
    );

    assign is_br = v_exe & (opcode_EXE == BTYPE_OP);
    assign mis   = is_br & (p_exe != jump_sel);

    // In RECOVER the EXE slot is a bubble, so resolution is masked there.
    assign flush_now = (state_reg == RUN) & mis & ~stall;
    assign upd_fire  = (state_reg == RUN) & is_br & ~stall;

    assign flush_IF    = flush_now;
    assign flush_ID    = flush_now;
    assign redirect    = flush_now;
    assign redirect_pc = !flush_now ? '0 :
                         jump_sel   ? target_EXE : (pc_EXE + PC_W'(4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= RUN;
            upd_en_reg    <= 1'b0;
            upd_taken_reg <= 1'b0;
        end else begin
            upd_en_reg    <= upd_fire;
            upd_taken_reg <= upd_fire & jump_sel;
            if (!stall) begin
                case (state_reg)
                    RUN:     if (mis) state_reg <= RECOVER;
                    RECOVER: state_reg <= RUN;
                    default: state_reg <= RUN;
                endcase
            end
        end
    end

    assign upd_en    = upd_en_reg;
    assign upd_taken = upd_taken_reg;

`ifdef PERF_CNT_EN
    // Slot 0 counts resolved branches, slot 1 counts mispredicts; both saturate.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_inc = {flush_now, upd_fire};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt_reg[gi] <= '0;
            else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
                cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
    end

    assign br_cnt  = cnt_reg[0];
    assign mis_cnt = cnt_reg[1];
`else
    assign br_cnt  = '0;
    assign mis_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Testbench for branch_resolve_ctrl: a vector table plus hand-written stall and reset sequences.
// A scoreboard queue holds the expected predictor updates and the cycle each one is due.
module tb_branch_resolve_ctrl;
    import branch_resolve_ctrl_pkg::*;

    localparam int PC_W  = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             Istall, Dstall, valid_IF, pred_taken_IF, jump_sel;
    logic [6:0]       opcode_EXE;
    logic [PC_W-1:0]  pc_EXE, target_EXE;
    logic             flush_IF, flush_ID, redirect, upd_en, upd_taken;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] br_cnt, mis_cnt;

    branch_resolve_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .Istall(Istall), .Dstall(Dstall),
        .valid_IF(valid_IF), .pred_taken_IF(pred_taken_IF),
        .opcode_EXE(opcode_EXE), .jump_sel(jump_sel),
        .pc_EXE(pc_EXE), .target_EXE(target_EXE),
        .flush_IF(flush_IF), .flush_ID(flush_ID), .redirect(redirect),
        .redirect_pc(redirect_pc), .upd_en(upd_en), .upd_taken(upd_taken),
        .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        pred;
        logic [6:0]  op;
        logic        jump;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        e_flush;
        logic [31:0] e_rpc;
        logic        e_upd;
    } vec_t;

    typedef struct {
        logic taken;
        int   due;
    } upd_t;

    vec_t             tbl [8];
    upd_t             sb_q [$];
    int               total = 0;
    int               bad   = 0;
    int               cyc   = 0;
    logic [CNT_W-1:0] exp_br  = '0;
    logic [CNT_W-1:0] exp_mis = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h want 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
    endfunction

    task automatic model_cnt(input logic upd, input logic mis);
`ifdef PERF_CNT_EN
        if (upd) exp_br  = sat_inc(exp_br);
        if (mis) exp_mis = sat_inc(exp_mis);
`endif
    endtask

    task automatic chk_cnt();
        chk("br_cnt",  32'(br_cnt),  32'(exp_br));
        chk("mis_cnt", 32'(mis_cnt), 32'(exp_mis));
    endtask

    // Each upd_en pulse must match the head of the queue, both outcome and cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (upd_en) begin
                if (sb_q.size() == 0) begin
                    chk("upd_unexpected", 32'(upd_en), 32'd0);
                end else begin
                    chk("upd_cycle", 32'(cyc), 32'(sb_q[0].due));
                    chk("upd_taken", 32'(upd_taken), 32'(sb_q[0].taken));
                    void'(sb_q.pop_front());
                end
            end else begin
                chk("upd_taken_idle", 32'(upd_taken), 32'd0);
                if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                    chk("upd_missing", 32'(upd_en), 32'd1);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic clear_exe();
        opcode_EXE = 7'h00;
        jump_sel   = 1'b0;
        pc_EXE     = '0;
        target_EXE = '0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        upd_t u;
        @(negedge clk);
        valid_IF = v.valid; pred_taken_IF = v.pred;
        @(negedge clk);
        valid_IF = 1'b0; pred_taken_IF = 1'b0;
        @(negedge clk);
        opcode_EXE = v.op; jump_sel = v.jump; pc_EXE = v.pc; target_EXE = v.tgt;
        #1;
        $display("vec %0d: flush=%0b redirect_pc=0x%h", idx, flush_IF, redirect_pc);
        chk("flush_IF",    32'(flush_IF), 32'(v.e_flush));
        chk("flush_ID",    32'(flush_ID), 32'(v.e_flush));
        chk("redirect",    32'(redirect), 32'(v.e_flush));
        chk("redirect_pc", redirect_pc,   v.e_rpc);
        if (v.e_upd) begin
            u.taken = v.jump; u.due = cyc + 1;
            sb_q.push_back(u);
        end
        model_cnt(v.e_upd, v.e_flush);
        @(negedge clk);
        clear_exe();
        chk_cnt();
    endtask

    task automatic stall_seq(input logic use_i, input int n, input logic pred, input logic jump,
                             input logic [31:0] pc, input logic [31:0] tgt,
                             input logic e_flush, input logic [31:0] e_rpc);
        upd_t u;
        @(negedge clk);
        valid_IF = 1'b1; pred_taken_IF = pred;
        @(negedge clk);
        valid_IF = 1'b0; pred_taken_IF = 1'b0;
        @(negedge clk);
        opcode_EXE = BTYPE_OP; jump_sel = jump; pc_EXE = pc; target_EXE = tgt;
        if (use_i) Istall = 1'b1; else Dstall = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("stall_flush",    32'(flush_IF), 32'd0);
            chk("stall_redirect", 32'(redirect), 32'd0);
        end
        @(negedge clk);
        Istall = 1'b0; Dstall = 1'b0;
        #1;
        $display("stall seq: released flush=%0b redirect_pc=0x%h", flush_IF, redirect_pc);
        chk("release_flush", 32'(flush_IF), 32'(e_flush));
        chk("release_rpc",   redirect_pc,   e_rpc);
        u.taken = jump; u.due = cyc + 1;
        sb_q.push_back(u);
        model_cnt(1'b1, e_flush);
        @(negedge clk);
        clear_exe();
        chk_cnt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, BTYPE_OP, 1'b1, 32'h0000_1000, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b1};
        tbl[1] = '{1'b1, 1'b1, BTYPE_OP, 1'b0, 32'hFFFF_FFFC, 32'h0000_2000, 1'b1, 32'h0000_0000, 1'b1};
        tbl[2] = '{1'b1, 1'b1, BTYPE_OP, 1'b1, 32'h0000_2000, 32'h0000_3000, 1'b0, 32'h0000_0000, 1'b1};
        tbl[3] = '{1'b1, 1'b0, BTYPE_OP, 1'b0, 32'h0000_2004, 32'h0000_3000, 1'b0, 32'h0000_0000, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 7'h6F,    1'b1, 32'h0000_2008, 32'h0000_4000, 1'b0, 32'h0000_0000, 1'b0};
        tbl[5] = '{1'b0, 1'b0, BTYPE_OP, 1'b1, 32'h0000_200C, 32'h0000_5000, 1'b0, 32'h0000_0000, 1'b0};
        tbl[6] = '{1'b1, 1'b1, BTYPE_OP, 1'b0, 32'h0000_0040, 32'h0000_0080, 1'b1, 32'h0000_0044, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 7'h33,    1'b0, 32'h0000_0050, 32'h0000_0090, 1'b0, 32'h0000_0000, 1'b0};

        rst = 1'b1; Istall = 1'b0; Dstall = 1'b0; valid_IF = 1'b0; pred_taken_IF = 1'b0;
        clear_exe();
        repeat (3) @(negedge clk);
        chk("rst_flush",  32'(flush_IF),  32'd0);
        chk("rst_upd_en", 32'(upd_en),    32'd0);
        chk("rst_rpc",    redirect_pc,    32'd0);
        rst = 1'b0;

        // Idle with jump_sel high: nothing in EXE is valid, so nothing may fire.
        jump_sel = 1'b1; opcode_EXE = BTYPE_OP;
        repeat (10) @(negedge clk);
        #1;
        $display("idle: flush=%0b redirect=%0b upd_en=%0b", flush_IF, redirect, upd_en);
        chk("idle_flush_IF",  32'(flush_IF),  32'd0);
        chk("idle_flush_ID",  32'(flush_ID),  32'd0);
        chk("idle_redirect",  32'(redirect),  32'd0);
        chk("idle_rpc",       redirect_pc,    32'd0);
        chk("idle_upd_en",    32'(upd_en),    32'd0);
        chk("idle_upd_taken", 32'(upd_taken), 32'd0);
        chk_cnt();
        clear_exe();

        for (int i = 0; i < 8; i++) apply_vec(tbl[i], i);

        stall_seq(1'b0, 3, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_0600, 1'b1, 32'h0000_0600);
        stall_seq(1'b1, 1, 1'b1, 1'b1, 32'h0000_0700, 32'h0000_0800, 1'b0, 32'h0000_0000);

        // Reset during the flush cycle: the pending update must be dropped.
        @(negedge clk);
        valid_IF = 1'b1; pred_taken_IF = 1'b0;
        @(negedge clk);
        valid_IF = 1'b0;
        @(negedge clk);
        opcode_EXE = BTYPE_OP; jump_sel = 1'b1; pc_EXE = 32'h0000_0900; target_EXE = 32'h0000_0A00;
        #1;
        chk("prerst_flush", 32'(flush_IF), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_flush", 32'(flush_IF), 32'd0);
        @(negedge clk);
        $display("mid-recover reset: upd_en=%0b flush=%0b", upd_en, flush_IF);
        chk("midrst_upd_en", 32'(upd_en), 32'd0);
        exp_br = '0; exp_mis = '0;
        chk_cnt();
        clear_exe();
        rst = 1'b0;

        // Five mispredicts in a row drive the 2-bit counters into saturation.
        for (int i = 0; i < 5; i++) apply_vec(tbl[0], 100 + i);
`ifdef PERF_CNT_EN
        chk("sat_mis_cnt", 32'(mis_cnt), 32'd3);
        chk("sat_br_cnt",  32'(br_cnt),  32'd3);
`else
        chk("off_mis_cnt", 32'(mis_cnt), 32'd0);
        chk("off_br_cnt",  32'(br_cnt),  32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
